// File: rtl/crypto_stream_unit_if.sv
// Stream interface for crypto_stream_unit.
// Carries the input word channel (with its mode bit) and the result channel.
// The master modport is the side that produces input words and consumes
// results; the slave modport is the cipher unit itself.
interface crypto_stream_unit_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/crypto_stream_unit.sv
// crypto_stream_unit: clocked stream cipher.
// Each accepted word is XORed with, and rotated by, the current value of a
// Galois LFSR keystream that is seeded by key_load and advances once per
// accepted word. Encrypt and decrypt are exact inverses for the same key and
// word order. The result is registered and handed out through valid/ready.
// Optional feature macro: CRYPTO_WORD_COUNT_EN adds a saturating 16-bit
// count of accepted words (word_cnt), cleared on reset and on key_load.
module crypto_stream_unit #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
    localparam int              RW    = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_load,
    input  logic [WIDTH-1:0]     key_in,
    output logic                 keyed,
    crypto_stream_unit_if.slave  bus
`ifdef CRYPTO_WORD_COUNT_EN
    ,
    output logic [15:0]          word_cnt
`endif
);

    typedef enum logic {
        S_NOKEY = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_keyed;
    logic [WIDTH-1:0] r_ks;
    logic             r_outValid;
    logic [WIDTH-1:0] r_outData;
`ifdef CRYPTO_WORD_COUNT_EN
    logic [15:0]      r_wordCnt;
`endif

    logic             w_inReady;
    logic             w_accept;
    logic [RW-1:0]    w_rot;
    logic [WIDTH-1:0] w_encWord;
    logic [WIDTH-1:0] w_decWord;
    logic [WIDTH-1:0] w_ksNext;
    logic [WIDTH-1:0] w_seed;

    // Rotate left by r using a doubled word so any r in range is a plain shift.
    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x,
                                              input logic [RW-1:0]    r);
        logic [2*WIDTH-1:0] t;
        t = {x, x} << r;
        return t[2*WIDTH-1:WIDTH];
    endfunction

    // Rotate right by r, the mirror image of rotl.
    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x,
                                              input logic [RW-1:0]    r);
        logic [2*WIDTH-1:0] t;
        t = {x, x} >> r;
        return t[WIDTH-1:0];
    endfunction

    // Handshake, cipher datapath and next keystream value; in_ready ignores in_valid.
    always_comb begin
        w_inReady = (r_state == S_RUN) & ~key_load & (~r_outValid | bus.out_ready);
        w_accept  = bus.in_valid & w_inReady;
        w_rot     = r_ks[RW-1:0];
        w_encWord = rotl(bus.in_data ^ r_ks, w_rot);
        w_decWord = rotr(bus.in_data, w_rot) ^ r_ks;
        w_ksNext  = (r_ks >> 1) ^ (r_ks[0] ? TAPS : '0);
        w_seed    = (key_in == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : key_in;
    end

    // Key FSM, keystream, registered result and optional word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_NOKEY;
            r_keyed    <= 1'b0;
            r_ks       <= '0;
            r_outValid <= 1'b0;
            r_outData  <= '0;
`ifdef CRYPTO_WORD_COUNT_EN
            r_wordCnt  <= 16'd0;
`endif
        end else begin
            if (key_load) begin
                r_state   <= S_RUN;
                r_keyed   <= 1'b1;
                r_ks      <= w_seed;
`ifdef CRYPTO_WORD_COUNT_EN
                r_wordCnt <= 16'd0;
`endif
            end else if (w_accept) begin
                r_ks      <= w_ksNext;
`ifdef CRYPTO_WORD_COUNT_EN
                if (r_wordCnt != 16'hFFFF) begin
                    r_wordCnt <= r_wordCnt + 16'd1;
                end
`endif
            end

            if (w_accept) begin
                r_outValid <= 1'b1;
                r_outData  <= bus.mode ? w_decWord : w_encWord;
            end else if (bus.out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = r_outValid;
    assign bus.out_data  = r_outData;
    assign keyed         = r_keyed;
`ifdef CRYPTO_WORD_COUNT_EN
    assign word_cnt      = r_wordCnt;
`endif

endmodule
